// File: rtl/counter.sv
// Parameterised synchronous up-counter with parallel load, count enable and
// synchronous active-low clear. The output comes straight from the count register.
module counter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             load,
   input  logic             enab,
   output logic [WIDTH-1:0] cnt_out
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Load beats enable; the increment wraps naturally modulo 2^WIDTH.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = cnt_in;
      end else if (enab) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_out = cnt_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios followed by random
// stimulus, all checked against an arithmetic reference model.
module tb_counter;

   localparam int W    = 5;
   localparam int MAXV = 1 << W;

   logic         clk;
   logic         rst;
   logic [W-1:0] cnt_in;
   logic         load;
   logic         enab;
   logic [W-1:0] cnt_out;

   int n_checks;
   int n_fail;
   int exp_cnt;

   counter #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .cnt_in  (cnt_in),
      .load    (load),
      .enab    (enab),
      .cnt_out (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: cnt_out=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: cnt_out=%0d", tag, got);
      end
   endtask

   // Apply one edge worth of inputs, advance the model, then compare after the edge.
   task automatic step(input string tag, input bit r, input bit l, input bit e, input int c);
      rst    = r;
      load   = l;
      enab   = e;
      cnt_in = W'(c);
      @(posedge clk);
      #1;
      if (!r)      exp_cnt = 0;
      else if (l)  exp_cnt = c % MAXV;
      else if (e)  exp_cnt = (exp_cnt + 1) % MAXV;
      check(tag, int'(cnt_out), exp_cnt);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = 0;
      rst = 1'b1; load = 1'b0; enab = 1'b0; cnt_in = '0;
      @(posedge clk);
      #1;

      // Reset state, with load and enable also asserted
      step("reset", 1'b0, 1'b1, 1'b1, 17);

      // Count sequence 0..30
      step("seq_load0", 1'b1, 1'b1, 1'b0, 0);
      for (int i = 1; i <= 30; i++) step("seq_count", 1'b1, 1'b0, 1'b1, $urandom_range(0, MAXV-1));

      // Wrap-around
      step("wrap_load31", 1'b1, 1'b1, 1'b0, MAXV-1);
      step("wrap_31_to_0", 1'b1, 1'b0, 1'b1, 5);
      step("wrap_load30", 1'b1, 1'b1, 1'b0, MAXV-2);
      step("wrap_30_to_31", 1'b1, 1'b0, 1'b1, 0);
      step("wrap_31_to_0b", 1'b1, 1'b0, 1'b1, 0);

      // Load sweep with enable asserted: load wins
      for (int i = 0; i < MAXV; i++) step("load_sweep", 1'b1, 1'b1, 1'b1, i);

      // Enable gating: idle edges hold regardless of cnt_in
      for (int i = 0; i < MAXV; i++) begin
         step("gate_load", 1'b1, 1'b1, 1'b0, i);
         for (int k = 0; k < 3; k++) step("gate_hold", 1'b1, 1'b0, 1'b0, $urandom_range(0, MAXV-1));
      end

      // Reset priority over idle and over load+enable
      for (int i = 0; i < MAXV; i++) begin
         step("rstpri_load", 1'b1, 1'b1, 1'b0, i);
         step("rstpri_idle", 1'b0, 1'b0, 1'b0, i);
         step("rstpri_load2", 1'b1, 1'b1, 1'b0, i);
         step("rstpri_all", 1'b0, 1'b1, 1'b1, i);
      end

      // Release from reset
      step("release_rst", 1'b0, 1'b0, 1'b0, 9);
      step("release_inc", 1'b1, 1'b0, 1'b1, 9);

      // Random mix of all controls
      for (int n = 0; n < 400; n++) begin
         step("random",
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 9) < 6),
              $urandom_range(0, MAXV-1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
